esi_manifest_reader: RTL and testbench

Host-facing read port for the zlib-compressed ESI manifest: serves the compressed byte array as 64-bit words over a valid/ready request/response channel, with burst reads. It is the responder counterpart to the manifest-setting path. Where no DPI link exists, host transport logic or an MMIO bridge fetches the manifest through this block. Instantiated once per design, next to the manifest constant.

---
 rtl/esi_manifest_pkg.sv | 19 +
 rtl/esi_manifest_word_mux.sv | 42 ++++
 rtl/esi_manifest_reader.sv | 112 +++++++++++
 tb/tb_esi_manifest_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esi_manifest_pkg.sv
// Shared types and constants for the ESI manifest read port.
// State encoding, header word layout and the manifest word-count helper.
package esi_manifest_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int HDR_VERSION_LSB = 32;
    localparam int HDR_SIZE_LSB    = 0;
    localparam int HDR_FIELD_W     = 32;

    // One header word followed by the manifest packed eight bytes per word.
    function automatic int num_words(input int size);
        return 1 + (size + 7) / 8;
    endfunction

endpackage

// File: rtl/esi_manifest_word_mux.sv
// Combinational word select over the manifest image: header word, packed
// manifest bytes with zero padding, and an out-of-range error flag.
module esi_manifest_word_mux
    import esi_manifest_pkg::*;
#(
    parameter int          SIZE        = 1,
    parameter logic [31:0] ESI_VERSION = 32'd1
) (
    input  logic [SIZE-1:0][7:0] manifest,
    input  logic [15:0]          addr,
    output logic [63:0]          word,
    output logic                 err
);

    localparam int NUM_WORDS = num_words(SIZE);
    localparam int SEL_W     = $clog2(NUM_WORDS);
    localparam int SLOTS     = 1 << SEL_W;

    logic [63:0]     header;
    logic [7:0][7:0] words [SLOTS];
    logic            in_range;

    assign header[HDR_VERSION_LSB +: HDR_FIELD_W] = ESI_VERSION;
    assign header[HDR_SIZE_LSB +: HDR_FIELD_W]    = 32'(SIZE);
    assign words[0] = header;

    // Slots past NUM_WORDS only exist to round the table to a power of two.
    for (genvar k = 1; k < SLOTS; k++) begin : g_word
        for (genvar j = 0; j < 8; j++) begin : g_byte
            if (k < NUM_WORDS && (8 * (k - 1) + j) < SIZE) begin : g_data
                assign words[k][j] = manifest[8 * (k - 1) + j];
            end else begin : g_pad
                assign words[k][j] = 8'h00;
            end
        end
    end

    assign in_range = 32'(addr) < 32'(NUM_WORDS);
    assign word     = in_range ? words[addr[SEL_W-1:0]] : 64'd0;
    assign err      = !in_range;

endmodule

// File: rtl/esi_manifest_reader.sv
// Host read port serving the compressed ESI manifest as 64-bit burst beats.
// Optional build macro ESI_MANIFEST_PARITY_EN adds even parity on resp_data.
module esi_manifest_reader
    import esi_manifest_pkg::*;
#(
    parameter int          COMPRESSED_MANIFEST_SIZE = 1,
    parameter logic [31:0] ESI_VERSION              = 32'd1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [COMPRESSED_MANIFEST_SIZE-1:0][7:0] compressed_manifest,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [15:0]                              req_addr,
    input  logic [7:0]                               req_len,
    output logic                                     resp_valid,
    input  logic                                     resp_ready,
    output logic [63:0]                              resp_data,
    output logic                                     resp_last,
    output logic                                     resp_err,
    output logic                                     resp_parity
);

    state_t      state;
    logic [15:0] addr;
    logic [7:0]  remaining;

    logic [15:0] mux_addr;
    logic [63:0] mux_word;
    logic        mux_err;
    logic        accept;
    logic        advance;
    logic        finish;

    assign accept  = (state == IDLE) && req_valid && req_ready;
    assign advance = (state == BURST) && resp_ready && (remaining != 8'd0);
    assign finish  = (state == BURST) && resp_ready && (remaining == 8'd0);

    // The mux looks one word ahead so the output register can load on the handshake.
    assign mux_addr = (state == IDLE) ? req_addr : addr + 16'd1;

    esi_manifest_word_mux #(
        .SIZE        (COMPRESSED_MANIFEST_SIZE),
        .ESI_VERSION (ESI_VERSION)
    ) u_word_mux (
        .manifest (compressed_manifest),
        .addr     (mux_addr),
        .word     (mux_word),
        .err      (mux_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= 16'd0;
            remaining  <= 8'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 64'd0;
            resp_last  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= BURST;
                        addr       <= req_addr;
                        remaining  <= req_len;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= mux_word;
                        resp_err   <= mux_err;
                        resp_last  <= (req_len == 8'd0);
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BURST: begin
                    if (finish) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_data  <= 64'd0;
                        resp_err   <= 1'b0;
                        resp_last  <= 1'b0;
                    end else if (advance) begin
                        addr      <= addr + 16'd1;
                        remaining <= remaining - 8'd1;
                        resp_data <= mux_word;
                        resp_err  <= mux_err;
                        resp_last <= (remaining == 8'd1);
                    end
                end
            endcase
        end
    end

`ifdef ESI_MANIFEST_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_parity <= 1'b0;
        end else if (accept || advance) begin
            resp_parity <= ^mux_word;
        end else if (finish) begin
            resp_parity <= 1'b0;
        end
    end
`else
    assign resp_parity = 1'b0;
`endif

endmodule

// File: tb/tb_esi_manifest_reader.sv
// Self-checking bench for esi_manifest_reader: directed scenarios plus
// randomized bursts compared against a word-level manifest model.
module tb_esi_manifest_reader;

    localparam int          SIZE      = 10;
    localparam logic [31:0] VER       = 32'd1;
    localparam int          NUM_WORDS = 1 + (SIZE + 7) / 8;
    localparam logic [63:0] HDR       = 64'h00000001_0000000A;
    localparam logic [63:0] W1        = 64'h08070605_04030201;
    localparam logic [63:0] W2        = 64'h00000000_00000A09;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [SIZE-1:0][7:0] manifest;
    logic                 req_valid;
    logic                 req_ready;
    logic [15:0]          req_addr;
    logic [7:0]           req_len;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [63:0]          resp_data;
    logic                 resp_last;
    logic                 resp_err;
    logic                 resp_parity;

    int total = 0;
    int bad   = 0;

    logic [63:0] obs_data [$];
    logic        obs_err  [$];
    logic        obs_last [$];
    logic        obs_par  [$];
    int          stall_changes;
    int          burst_cycles;
    logic        first_valid;
    logic        after_ready;
    logic        after_valid;

    esi_manifest_reader #(
        .COMPRESSED_MANIFEST_SIZE (SIZE),
        .ESI_VERSION              (VER)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .compressed_manifest (manifest),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_data           (resp_data),
        .resp_last           (resp_last),
        .resp_err            (resp_err),
        .resp_parity         (resp_parity)
    );

    always #5 clk = ~clk;

    // Reference image: header, then manifest bytes little-endian per word, zero padded.
    function automatic logic [63:0] ref_word(input logic [15:0] a);
        logic [63:0] w;
        int          ai;
        int          idx;
        w  = '0;
        ai = a;
        if (ai == 0) begin
            w = {VER, 32'(SIZE)};
        end else if (ai < NUM_WORDS) begin
            for (int j = 0; j < 8; j++) begin
                idx = 8 * (ai - 1) + j;
                if (idx < SIZE) w[8*j +: 8] = manifest[idx];
            end
        end
        return w;
    endfunction

    function automatic logic ref_err(input logic [15:0] a);
        int ai;
        ai = a;
        return ai >= NUM_WORDS;
    endfunction

    function automatic logic ref_par(input logic [63:0] w);
`ifdef ESI_MANIFEST_PARITY_EN
        return ^w;
`else
        return (w === 64'hx);
`endif
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues one request and records every accepted beat; hold forces the first stall cycles.
    task automatic do_burst(input logic [15:0] a, input logic [7:0] l, input int ready_pct,
                            input int hold, output bit timeout);
        int          cyc;
        bit          done;
        bit          dropped;
        bit          stalled;
        logic [63:0] pd;
        logic        pe, pl, pp;
        obs_data.delete();
        obs_err.delete();
        obs_last.delete();
        obs_par.delete();
        stall_changes = 0;
        burst_cycles  = 0;
        first_valid   = 1'b0;
        after_ready   = 1'b0;
        after_valid   = 1'b1;
        timeout       = 1'b0;
        pd = '0; pe = 1'b0; pl = 1'b0; pp = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (req_ready !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid   = 1'b0;
        first_valid = resp_valid;
        done = 1'b0; dropped = 1'b0; stalled = 1'b0; cyc = 0;
        while (!done && !dropped && cyc < 2000) begin
            if (stalled && (resp_data !== pd || resp_err !== pe || resp_last !== pl
                            || resp_parity !== pp)) stall_changes++;
            if (resp_valid !== 1'b1) begin
                dropped = 1'b1;
            end else begin
                resp_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
                if (resp_ready) begin
                    obs_data.push_back(resp_data);
                    obs_err.push_back(resp_err);
                    obs_last.push_back(resp_last);
                    obs_par.push_back(resp_parity);
                    if (resp_last === 1'b1) done = 1'b1;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = resp_data; pe = resp_err; pl = resp_last; pp = resp_parity;
                end
                @(negedge clk);
                cyc++;
            end
        end
        resp_ready   = 1'b0;
        burst_cycles = cyc;
        after_ready  = req_ready;
        after_valid  = resp_valid;
        if (!done) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        total++; if (resp_data !== 64'd0) begin bad++; $display("[TB] FAIL reset_resp_data: got %h expected 0", resp_data); end
        total++; if ({resp_last, resp_err, resp_parity} !== 3'b000) begin bad++; $display("[TB] FAIL reset_resp_flags: got %b expected 000", {resp_last, resp_err, resp_parity}); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b expected 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_valid: got %b expected 0", resp_valid); end
    endtask

    task automatic test_single_read();
        bit to;
        do_burst(16'd0, 8'd0, 100, 0, to);
        total++; if (to || obs_data.size() != 1) begin bad++; $display("[TB] FAIL single_beats: got %0d timeout=%0b expected 1", obs_data.size(), to); end
        total++; if (first_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_latency: got %b expected 1", first_valid); end
        total++; if (obs_data[0] !== HDR) begin bad++; $display("[TB] FAIL single_data: got %h expected %h", obs_data[0], HDR); end
        total++; if ({obs_last[0], obs_err[0]} !== 2'b10) begin bad++; $display("[TB] FAIL single_last_err: got %b expected 10", {obs_last[0], obs_err[0]}); end
        total++; if (obs_par[0] !== ref_par(HDR)) begin bad++; $display("[TB] FAIL single_parity: got %b expected %b", obs_par[0], ref_par(HDR)); end
        total++; if ({after_ready, after_valid} !== 2'b10) begin bad++; $display("[TB] FAIL single_return_idle: got %b expected 10", {after_ready, after_valid}); end
    endtask

    task automatic test_burst();
        bit          to;
        logic [63:0] exp_w [3];
        exp_w = '{HDR, W1, W2};
        do_burst(16'd0, 8'd2, 100, 0, to);
        total++; if (to || obs_data.size() != 3) begin bad++; $display("[TB] FAIL burst_beats: got %0d timeout=%0b expected 3", obs_data.size(), to); end
        total++; if (burst_cycles != 3) begin bad++; $display("[TB] FAIL burst_cycles: got %0d expected 3", burst_cycles); end
        for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_w[i]) begin bad++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", i, obs_data[i], exp_w[i]); end
            total++; if (obs_last[i] !== (i == 2)) begin bad++; $display("[TB] FAIL burst_last[%0d]: got %b expected %b", i, obs_last[i], i == 2); end
            total++; if (obs_par[i] !== ref_par(exp_w[i])) begin bad++; $display("[TB] FAIL burst_parity[%0d]: got %b expected %b", i, obs_par[i], ref_par(exp_w[i])); end
            total++; if (obs_err[i] !== 1'b0) begin bad++; $display("[TB] FAIL burst_err[%0d]: got %b expected 0", i, obs_err[i]); end
        end
    endtask

    task automatic test_out_of_range();
        bit to;
        do_burst(16'd2, 8'd1, 100, 0, to);
        total++; if (to || obs_data.size() != 2) begin bad++; $display("[TB] FAIL oor_beats: got %0d timeout=%0b expected 2", obs_data.size(), to); end
        total++; if (obs_data[0] !== W2 || obs_err[0] !== 1'b0 || obs_last[0] !== 1'b0) begin bad++; $display("[TB] FAIL oor_beat0: got %h/%b/%b expected %h/0/0", obs_data[0], obs_err[0], obs_last[0], W2); end
        total++; if (obs_data[1] !== 64'd0 || obs_err[1] !== 1'b1 || obs_last[1] !== 1'b1) begin bad++; $display("[TB] FAIL oor_beat1: got %h/%b/%b expected 0/1/1", obs_data[1], obs_err[1], obs_last[1]); end
        total++; if (obs_par[1] !== 1'b0) begin bad++; $display("[TB] FAIL oor_parity: got %b expected 0", obs_par[1]); end
    endtask

    task automatic test_backpressure();
        bit to;
        do_burst(16'd1, 8'd1, 100, 4, to);
        total++; if (to || obs_data.size() != 2) begin bad++; $display("[TB] FAIL bp_beats: got %0d timeout=%0b expected 2", obs_data.size(), to); end
        total++; if (stall_changes != 0) begin bad++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", stall_changes); end
        total++; if (burst_cycles != 6) begin bad++; $display("[TB] FAIL bp_cycles: got %0d expected 6", burst_cycles); end
        total++; if (obs_data[0] !== W1 || obs_data[1] !== W2) begin bad++; $display("[TB] FAIL bp_data: got %h,%h expected %h,%h", obs_data[0], obs_data[1], W1, W2); end
    endtask

    task automatic test_wrap();
        bit to;
        do_burst(16'hFFFF, 8'd1, 100, 0, to);
        total++; if (to || obs_data.size() != 2) begin bad++; $display("[TB] FAIL wrap_beats: got %0d timeout=%0b expected 2", obs_data.size(), to); end
        total++; if (obs_data[0] !== 64'd0 || obs_err[0] !== 1'b1 || obs_last[0] !== 1'b0) begin bad++; $display("[TB] FAIL wrap_beat0: got %h/%b/%b expected 0/1/0", obs_data[0], obs_err[0], obs_last[0]); end
        total++; if (obs_data[1] !== HDR || obs_err[1] !== 1'b0 || obs_last[1] !== 1'b1) begin bad++; $display("[TB] FAIL wrap_beat1: got %h/%b/%b expected %h/0/1", obs_data[1], obs_err[1], obs_last[1], HDR); end
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        req_valid = 1'b1; req_addr = 16'd0; req_len = 8'd255;
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_active: got %b expected 1", resp_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_async_clear: got valid=%b ready=%b expected 0,0", resp_valid, req_ready); end
        total++; if (resp_data !== 64'd0 || resp_last !== 1'b0) begin bad++; $display("[TB] FAIL midrst_data_clear: got %h/%b expected 0/0", resp_data, resp_last); end
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_idle: got ready=%b valid=%b expected 1,0", req_ready, resp_valid); end
        do_burst(16'd1, 8'd0, 100, 0, to);
        total++; if (to || obs_data.size() != 1 || obs_data[0] !== W1 || obs_last[0] !== 1'b1) begin bad++; $display("[TB] FAIL midrst_reread: got %h beats=%0d expected %h beats=1", obs_data[0], obs_data.size(), W1); end
    endtask

    task automatic test_random();
        bit          to;
        logic [15:0] a;
        logic [7:0]  l;
        logic [15:0] ba;
        logic [63:0] ew;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       a = 16'($urandom_range(0, 5));
                1:       a = 16'hFFFF - 16'($urandom_range(0, 4));
                default: a = 16'($urandom_range(0, 65535));
            endcase
            l = ($urandom_range(0, 9) == 0) ? 8'd40 : 8'($urandom_range(0, 12));
            do_burst(a, l, $urandom_range(30, 100), $urandom_range(0, 3), to);
            total++;
            if (to || obs_data.size() != int'(l) + 1) begin
                bad++;
                $display("[TB] FAIL rand_beats: got %0d timeout=%0b expected %0d (addr=%h)", obs_data.size(), to, int'(l) + 1, a);
                do_reset();
            end else begin
                for (int i = 0; i <= int'(l); i++) begin
                    ba = a + 16'(i);
                    ew = ref_word(ba);
                    total++; if (obs_data[i] !== ew) begin bad++; $display("[TB] FAIL rand_data: got %h expected %h (addr=%h)", obs_data[i], ew, ba); end
                    total++; if (obs_err[i] !== ref_err(ba)) begin bad++; $display("[TB] FAIL rand_err: got %b expected %b (addr=%h)", obs_err[i], ref_err(ba), ba); end
                    total++; if (obs_last[i] !== (i == int'(l))) begin bad++; $display("[TB] FAIL rand_last: got %b expected %b (beat %0d)", obs_last[i], i == int'(l), i); end
                    total++; if (obs_par[i] !== ref_par(ew)) begin bad++; $display("[TB] FAIL rand_parity: got %b expected %b (addr=%h)", obs_par[i], ref_par(ew), ba); end
                end
                total++; if (stall_changes != 0) begin bad++; $display("[TB] FAIL rand_stable: got %0d changes expected 0", stall_changes); end
                total++; if (after_ready !== 1'b1) begin bad++; $display("[TB] FAIL rand_return_idle: got %b expected 1", after_ready); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) manifest[i] = 8'(i + 1);
        test_reset();
        test_single_read();
        test_burst();
        test_out_of_range();
        test_backpressure();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
